regfile_dump_reader: RTL

Debug read-out engine that walks the 32-entry integer register file and streams every register out over a valid/ready interface, one entry at a time. It drives a dedicated read address into the register file's combinational read port and captures the returned data. While a dump is in progress it asserts a stall request, so the core's writeback does not change registers mid-dump. It sits beside the register file and feeds the debug/trace path.

---
 rtl/regfile_dump_reader_pkg.sv | 21 ++
 rtl/regfile_dump_reader.sv | 108 ++++++++++
 2 files changed

// File: rtl/regfile_dump_reader_pkg.sv
//------------------------------------------------------------------------------
// regfile_dump_reader_pkg
// Shared state encoding and default geometry for the register-file dump reader.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package regfile_dump_reader_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/regfile_dump_reader.sv
//------------------------------------------------------------------------------
// regfile_dump_reader
// Walks the integer register file and streams each entry over valid/ready.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_dump_reader #(
   parameter int NUM_REGS = regfile_dump_reader_pkg::NUM_REGS,
   parameter int ADDR_W   = regfile_dump_reader_pkg::REG_ADDR_W,
   parameter int DATA_W   = regfile_dump_reader_pkg::XLEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   import regfile_dump_reader_pkg::*;

   localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_REGS - 1);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [ADDR_W-1:0] r_index;
   logic              r_last;
   logic              w_handshake;

   assign w_handshake = r_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_index <= '0;
         r_last  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_ptr   <= '0;
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  r_ptr   <= '0;
                  r_valid <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_data  <= rd_data;
                  r_index <= r_ptr;
                  r_last  <= (r_ptr == c_last_idx);
                  r_valid <= 1'b1;
                  r_state <= ST_SEND;
               end
            end
            ST_SEND: begin
               // Abort wins over a handshake in the same cycle: the entry is dropped.
               if (abort) begin
                  r_ptr   <= '0;
                  r_valid <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (w_handshake) begin
                  r_valid <= 1'b0;
                  if (r_last) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_ptr   <= r_ptr + ADDR_W'(1);
                     r_state <= ST_LOAD;
                  end
               end
            end
            ST_DONE: begin
               r_ptr   <= '0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rd_addr   = r_ptr;
   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_index = r_index;
   assign out_last  = r_last;
   assign busy      = (r_state == ST_LOAD) || (r_state == ST_SEND);
   assign done      = (r_state == ST_DONE);

endmodule

`default_nettype wire
